// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//   Up/down event/timer counter with a runtime-programmable inclusive upper
//   limit, parallel load, wrap-or-saturate behaviour at the limits, a
//   registered one-cycle terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH     : width of count, load_val and max_val (>= 2)
//   RESET_VAL : count value after reset
//   SATURATE  : 0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst       in   synchronous active-high reset, overrides everything
//   en        in   count enable, one step per cycle
//   up        in   step direction when en (1 = increment, 0 = decrement)
//   load      in   parallel load request, takes priority over en
//   load_val  in   value written on load (not clamped to max_val)
//   max_val   in   inclusive upper limit, used combinationally every cycle
//   ovf_clr   in   clears ovf unless a limit event occurs in the same cycle
//   count     out  registered counter value
//   tc        out  registered pulse, high the cycle after a limit event
//   ovf       out  sticky limit-event flag
//   zero      out  combinational count == 0
// ---------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0,
  parameter bit                     SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             limit_evt;

  always_comb begin
    count_d   = count_q;
    limit_evt = 1'b0;

    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (up) begin
        // A count loaded above the limit is treated as being at the limit,
        // so the increment can never step past max_val (even all-ones).
        if (count_q >= max_val) begin
          limit_evt = 1'b1;
          count_d   = SATURATE ? max_val : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        // Counting down from above the limit first pulls the count back
        // into range; that resync is not a limit event.
        if (count_q > max_val) begin
          count_d = max_val;
        end else if (count_q == '0) begin
          limit_evt = 1'b1;
          count_d   = SATURATE ? '0 : max_val;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end

    tc_d  = limit_evt;
    // Setting wins over a simultaneous clear so no event is lost.
    ovf_d = limit_evt | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

  localparam int W    = 8;
  localparam int RV_W = 0;
  localparam int RV_S = 3;

  logic         clk = 1'b0;
  logic         rst, en, up, load, ovf_clr;
  logic [W-1:0] load_val, max_val;

  logic [W-1:0] cnt_w, cnt_s;
  logic         tc_w, tc_s, ovf_w, ovf_s, zero_w, zero_s;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int mc_w, mc_s;
  bit mt_w, mt_s, mo_w, mo_s;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(W), .RESET_VAL(8'(RV_W)), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .max_val(max_val), .ovf_clr(ovf_clr), .count(cnt_w), .tc(tc_w), .ovf(ovf_w),
    .zero(zero_w)
  );

  updown_mod_counter #(.WIDTH(W), .RESET_VAL(8'(RV_S)), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .max_val(max_val), .ovf_clr(ovf_clr), .count(cnt_s), .tc(tc_s), .ovf(ovf_s),
    .zero(zero_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written directly from the counting rules.
  task automatic mstep(input bit sat, input int rv, inout int c, inout bit t, inout bit o);
    bit ev;
    int m;
    ev = 1'b0;
    m  = int'(max_val);
    if (rst) begin
      c = rv; t = 1'b0; o = 1'b0;
    end else begin
      if (load) c = int'(load_val);
      else if (en && up) begin
        if (c < m) c = c + 1;
        else begin ev = 1'b1; c = sat ? m : 0; end
      end else if (en) begin
        if (c > m) c = m;
        else if (c == 0) begin ev = 1'b1; c = sat ? 0 : m; end
        else c = c - 1;
      end
      t = ev;
      o = ev || (o && !ovf_clr);
    end
  endtask

  always @(posedge clk) begin
    mstep(1'b0, RV_W, mc_w, mt_w, mo_w);
    mstep(1'b1, RV_S, mc_s, mt_s, mo_s);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_w_count", int'(cnt_w), mc_w);
      chk("model_w_tc",    int'(tc_w),  int'(mt_w));
      chk("model_w_ovf",   int'(ovf_w), int'(mo_w));
      chk("model_w_zero",  int'(zero_w), int'(mc_w == 0));
      chk("model_s_count", int'(cnt_s), mc_s);
      chk("model_s_tc",    int'(tc_s),  int'(mt_s));
      chk("model_s_ovf",   int'(ovf_s), int'(mo_s));
      chk("model_s_zero",  int'(zero_s), int'(mc_s == 0));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input int lv, input int mv, input bit oc);
    rst = r; en = e; up = u; load = l;
    load_val = 8'(lv); max_val = 8'(mv); ovf_clr = oc;
  endtask

  int exp2[6] = '{1, 2, 3, 4, 5, 0};
  int exp3[3] = '{0, 5, 4};
  int tc3[3]  = '{0, 1, 0};
  int exp4[4] = '{199, 200, 200, 200};
  int tc4[4]  = '{0, 0, 1, 1};

  initial begin
    // Reset held two cycles with en and load active.
    drive(1, 1, 1, 1, 77, 200, 0);
    cyc(); cyc();
    chk("rst_w_count", int'(cnt_w), RV_W);
    chk("rst_s_count", int'(cnt_s), RV_S);
    chk("rst_w_tc", int'(tc_w), 0);
    chk("rst_w_ovf", int'(ovf_w), 0);
    chk("rst_s_ovf", int'(ovf_s), 0);
    chk("rst_w_zero", int'(zero_w), 1);
    chk("rst_s_zero", int'(zero_s), 0);
    chk_on = 1'b1;

    // Wrap up through max_val = 5.
    drive(0, 0, 1, 1, 0, 5, 0);
    cyc();
    drive(0, 1, 1, 0, 0, 5, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("wrap_up_count", int'(cnt_w), exp2[i]);
      chk("wrap_up_tc", int'(tc_w), (i == 5) ? 1 : 0);
    end
    drive(0, 0, 1, 0, 0, 5, 0);
    cyc();
    chk("wrap_up_ovf", int'(ovf_w), 1);
    chk("wrap_up_tc_idle", int'(tc_w), 0);

    // Wrap down from 1.
    drive(0, 0, 0, 1, 1, 5, 0);
    cyc();
    drive(0, 1, 0, 0, 0, 5, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wrap_dn_count", int'(cnt_w), exp3[i]);
      chk("wrap_dn_tc", int'(tc_w), tc3[i]);
    end

    // Saturate at 200 going up, then hold at 0 going down.
    drive(0, 0, 1, 1, 198, 200, 0);
    cyc();
    drive(0, 1, 1, 0, 0, 200, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_up_count", int'(cnt_s), exp4[i]);
      chk("sat_up_tc", int'(tc_s), tc4[i]);
    end
    drive(0, 0, 0, 1, 0, 200, 0);
    cyc();
    drive(0, 1, 0, 0, 0, 200, 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("sat_dn_count", int'(cnt_s), 0);
      chk("sat_dn_tc", int'(tc_s), 1);
    end

    // Load beats en; load above the limit; all-ones limit.
    drive(0, 1, 1, 1, 250, 100, 0);
    cyc();
    chk("prio_load_count", int'(cnt_w), 250);
    chk("prio_load_tc", int'(tc_w), 0);
    drive(0, 1, 1, 0, 0, 100, 0);
    cyc();
    chk("above_up_count", int'(cnt_w), 0);
    chk("above_up_tc", int'(tc_w), 1);
    drive(0, 0, 0, 1, 250, 100, 0);
    cyc();
    drive(0, 1, 0, 0, 0, 100, 0);
    cyc();
    chk("resync_dn_count", int'(cnt_w), 100);
    chk("resync_dn_tc", int'(tc_w), 0);
    drive(0, 0, 1, 1, 254, 255, 0);
    cyc();
    drive(0, 1, 1, 0, 0, 255, 0);
    cyc();
    chk("allones_count", int'(cnt_w), 255);
    cyc();
    chk("allones_wrap", int'(cnt_w), 0);
    chk("allones_tc", int'(tc_w), 1);

    // max_val = 0: every up step is a limit event.
    drive(0, 1, 1, 0, 0, 0, 0);
    cyc(); cyc();
    chk("max0_count", int'(cnt_w), 0);
    chk("max0_tc", int'(tc_w), 1);

    // ovf clear/set interplay and reset over a pending tc.
    drive(0, 0, 1, 1, 100, 100, 1);
    cyc();
    chk("ovf_clr_only", int'(ovf_w), 0);
    drive(0, 1, 1, 0, 0, 100, 1);
    cyc();
    chk("ovf_set_wins", int'(ovf_w), 1);
    chk("ovf_set_tc", int'(tc_w), 1);
    drive(0, 0, 1, 0, 0, 100, 1);
    cyc();
    chk("ovf_clr_after", int'(ovf_w), 0);
    drive(0, 0, 1, 1, 100, 100, 0);
    cyc();
    drive(1, 1, 1, 0, 0, 100, 0);
    cyc();
    chk("rst_tc_count", int'(cnt_w), RV_W);
    chk("rst_tc_tc", int'(tc_w), 0);
    chk("rst_tc_ovf", int'(ovf_w), 0);

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      int mv, sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      mv = int'($urandom_range(0, 7));
      else if (sel < 5) mv = 255;
      else              mv = int'($urandom_range(0, 255));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 255)), mv, ($urandom_range(0, 15) == 0));
      cyc();
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
